bus_arbiter_rr: RTL

//  Registered round-robin arbiter for the shared system bus. It takes the per-master
//  bus_req vector (bit 0 ICache, bit 1 DCache, bits 2..7 future masters) and produces a
//  one-hot, registered bus_ack.
//  It sits directly upstream of the BlockRAM bus slave. The bus is an OR-combined

---
 rtl/bus_arbiter_rr.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// Registered round-robin arbiter for the shared OR-combined system bus: one-hot grant,
// hold until release, one idle cycle between owners, plus hold-time and transfer statistics.
module bus_arbiter_rr #(
  parameter int NREQ     = 8,
  parameter int OWNER_W  = 3,
  parameter int MAX_HOLD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    bus_req,
  input  logic               bus_ready,
  output logic [NREQ-1:0]    bus_ack,
  output logic               bus_busy,
  output logic [OWNER_W-1:0] bus_owner,
  output logic               hold_timeout,
  output logic [15:0]        txn_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_r, state_s;
  logic [NREQ-1:0]      ack_r, ack_s;
  logic [OWNER_W-1:0]   owner_r, owner_s;
  logic [OWNER_W-1:0]   last_ptr_r, last_ptr_s;
  logic [OWNER_W-1:0]   winner_s;
  logic                 found_s;
  logic                 owner_req_s;
  logic [OWNER_W:0]     scan_idx_s;
  logic [15:0]          hold_cnt_r, hold_cnt_s;
  logic                 timeout_r, timeout_s;
  logic [15:0]          txn_r;

  // Rotating priority search; scanning downward lets the nearest index after last_ptr win.
  always_comb begin
    winner_s   = {OWNER_W{1'b0}};
    found_s    = 1'b0;
    scan_idx_s = {(OWNER_W+1){1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      scan_idx_s = {1'b0, last_ptr_r} + (OWNER_W+1)'(i);
      scan_idx_s = (scan_idx_s >= (OWNER_W+1)'(NREQ)) ? scan_idx_s - (OWNER_W+1)'(NREQ) : scan_idx_s;
      if (|(bus_req & (NREQ'(1) << scan_idx_s))) begin
        winner_s = OWNER_W'(scan_idx_s);
        found_s  = 1'b1;
      end else begin
        winner_s = winner_s;
        found_s  = found_s;
      end
    end
  end

  // The grant vector is one-hot on the owner, so masking it picks out the owner's request.
  assign owner_req_s = |(bus_req & ack_r);

  // Next-state and next-grant logic.
  always_comb begin
    state_s    = state_r;
    ack_s      = ack_r;
    owner_s    = owner_r;
    last_ptr_s = last_ptr_r;
    hold_cnt_s = hold_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s    = GRANT;
          ack_s      = NREQ'(1) << winner_s;
          owner_s    = winner_s;
          last_ptr_s = winner_s;
          hold_cnt_s = 16'd1;
        end else begin
          ack_s = {NREQ{1'b0}};
        end
      end
      GRANT: begin
        if (owner_req_s) begin
          hold_cnt_s = (hold_cnt_r == 16'hFFFF) ? hold_cnt_r : hold_cnt_r + 16'd1;
        end else begin
          state_s = IDLE;
          ack_s   = {NREQ{1'b0}};
        end
      end
      default: begin
        state_s = IDLE;
        ack_s   = {NREQ{1'b0}};
      end
    endcase
    timeout_s = timeout_r | ((state_s == GRANT) && (hold_cnt_s >= 16'(MAX_HOLD)));
  end

  // State and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ack_r      <= {NREQ{1'b0}};
      owner_r    <= {OWNER_W{1'b0}};
      last_ptr_r <= OWNER_W'(NREQ - 1);
      hold_cnt_r <= 16'd0;
      timeout_r  <= 1'b0;
      txn_r      <= 16'd0;
    end else begin
      state_r    <= state_s;
      ack_r      <= ack_s;
      owner_r    <= owner_s;
      last_ptr_r <= last_ptr_s;
      hold_cnt_r <= hold_cnt_s;
      timeout_r  <= timeout_s;
      txn_r      <= ((|ack_r) && bus_ready) ? txn_r + 16'd1 : txn_r;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus_ack      = ack_r;
    bus_busy     = |ack_r;
    bus_owner    = owner_r;
    hold_timeout = timeout_r;
    txn_count    = txn_r;
  end

endmodule
